// File: rtl/seg7_pkg.sv
// Purpose: shared types, constants and helpers for the 7-segment scroll sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    RUN     = 2'd2
  } seg7_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Map one nibble to its upper-case ASCII hex character.
  function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Purpose: digit-scan timer producing select and a registered frame tick.
// Latency: select steps every REFRESH_DIV cycles; first tick 4*REFRESH_DIV cycles after reset.
// Backpressure: none, free-running.
module seg7_refresh_timer #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] select_o,
  output logic       frame_tick_o,
  output logic       frame_end_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    sel_q;
  logic          tick_q;
  logic          slot_end;

  // frame_end_o is high in the cycle before select wraps to 0; consumers
  // load on that edge so their outputs move together with frame_tick_o.
  assign slot_end    = (cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end_o = slot_end && (sel_q == 2'd3);

  // Refresh counter, digit index and registered wrap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= slot_end ? '0 : cnt_q + CW'(1);
      if (slot_end) begin
        sel_q <= sel_q + 2'd1;
      end
      tick_q <= frame_end_o;
    end
  end

  assign select_o     = sel_q;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Purpose: message buffer, load FSM, scroll logic and tear-free 4-char ASCII window.
// Latency: window changes appear at the first frame boundary after they are registered.
// Backpressure: wrReady is registered and drops the cycle after the final accepted char.
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 250,
  parameter int MSG_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic [15:0] hexValue,
  input  logic        wrValid,
  input  logic [7:0]  wrChar,
  input  logic        wrLast,
  output logic        wrReady,
  input  logic        clear,
  output logic [1:0]  select,
  output logic [31:0] asciiDigits,
  output logic        frameTick
);

  localparam int LW  = $clog2(MSG_DEPTH + 1);
  localparam int SW  = $clog2(MSG_DEPTH + 4);
  localparam int PW  = SW + 1;
  localparam int AW  = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  seg7_state_e    state_q;
  logic [LW-1:0]  len_q;
  logic           wr_ready_q;
  logic [7:0]     msg_q [MSG_DEPTH];
  logic [SW-1:0]  start_q, start_d;
  logic [SCW-1:0] scroll_q, scroll_d;
  logic           mode_q;
  logic [31:0]    win_q, win_d;

  logic           frame_end;
  logic           xfer;
  logic           mode_chg;
  logic           scrolling;
  logic [PW-1:0]  period;
  logic [SW-1:0]  start_win;
  logic [PW-1:0]  pos;

  seg7_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .select_o     (select),
    .frame_tick_o (frameTick),
    .frame_end_o  (frame_end)
  );

  assign xfer      = wrValid && wr_ready_q;
  assign mode_chg  = (mode != mode_q);
  assign scrolling = mode && (state_q == RUN) && (len_q > LW'(4));
  assign period    = PW'(len_q) + PW'(4);
  assign start_win = (scrolling && !mode_chg) ? start_q : '0;

  // Load FSM: accepts characters until wrLast or a full buffer; clear wins over a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      len_q      <= '0;
      wr_ready_q <= 1'b0;
    end else if (clear) begin
      state_q    <= EMPTY;
      len_q      <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY, LOADING: begin
          wr_ready_q <= 1'b1;
          if (xfer) begin
            len_q <= len_q + LW'(1);
            if (wrLast || (len_q == LW'(MSG_DEPTH - 1))) begin
              state_q    <= RUN;
              wr_ready_q <= 1'b0;
            end else begin
              state_q <= LOADING;
            end
          end
        end
        RUN: begin
          wr_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= EMPTY;
          len_q      <= '0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Character storage at the write pointer; not reset, length masks stale entries.
  always_ff @(posedge clk) begin
    if (xfer && !clear) begin
      msg_q[len_q[AW-1:0]] <= wrChar;
    end
  end

  // Next window start and frame-divider count for the scroll step.
  always_comb begin
    start_d  = start_q;
    scroll_d = scroll_q;
    if (clear || mode_chg) begin
      start_d  = '0;
      scroll_d = '0;
    end else if (frame_end && scrolling) begin
      if (scroll_q == SCW'(SCROLL_DIV - 1)) begin
        scroll_d = '0;
        start_d  = (PW'(start_q) == (period - PW'(1))) ? '0 : start_q + SW'(1);
      end else begin
        scroll_d = scroll_q + SCW'(1);
      end
    end
  end

  // Candidate window: hex conversion, or message chars indexed modulo the padded period.
  always_comb begin
    win_d = {4{ASCII_SPACE}};
    pos   = '0;
    if (!mode) begin
      win_d = {hex_nibble_to_ascii(hexValue[15:12]), hex_nibble_to_ascii(hexValue[11:8]),
               hex_nibble_to_ascii(hexValue[7:4]),   hex_nibble_to_ascii(hexValue[3:0])};
    end else begin
      for (int i = 0; i < 4; i++) begin
        // start < period and i < 4 < period, so one subtract is enough.
        pos = PW'(start_win) + PW'(i);
        if (scrolling && (pos >= period)) begin
          pos = pos - period;
        end
        if (pos < PW'(len_q)) begin
          win_d[8*(3-i) +: 8] = msg_q[pos[AW-1:0]];
        end
      end
    end
  end

  // Scroll state, mode history and the window register, loaded only at frame boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q  <= '0;
      scroll_q <= '0;
      mode_q   <= 1'b0;
      win_q    <= {4{ASCII_SPACE}};
    end else begin
      start_q  <= start_d;
      scroll_q <= scroll_d;
      mode_q   <= mode;
      if (frame_end) begin
        win_q <= win_d;
      end
    end
  end

  assign wrReady     = wr_ready_q;
  assign asciiDigits = win_q;

endmodule

// File: doc/seg7_scroll_ctrl.md
# seg7_scroll_ctrl

Sequencer for the 4-digit multiplexed 7-segment display. It generates the digit-scan `select`. It holds a message buffer of up to 16 ASCII characters, loaded through a valid/ready stream. It presents a 4-character window as a packed 32-bit ASCII word, which feeds the existing packed-ASCII digit mux and the ASCII-to-segment decoder. In hex mode it converts a 16-bit value to four ASCII hex characters, so the display uses one decode path.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per digit slot. Minimum 1.
- `SCROLL_DIV`, 250: full frames (4 digit slots) per scroll step. Minimum 1.
- `MSG_DEPTH`, 16: buffer capacity in characters. Minimum 4.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, **synchronous, active-low** (one clock domain).
- `mode` in 1: 0 = hex display of `hexValue`; 1 = message display.
- `hexValue` in 16: value shown in hex mode.
- `wrValid` in 1: producer presents `wrChar`.
- `wrChar` in 8: ASCII character.
- `wrLast` in 1: this is the final character of the message.
- `wrReady` out 1: buffer accepts characters.
- `clear` in 1: discard the message and return to EMPTY.
- `select` out 2: digit index; 3 is the leftmost digit.
- `asciiDigits` out 32: window; [31:24] is the leftmost digit, [7:0] the rightmost.
- `frameTick` out 1: one-cycle pulse when `select` wraps from 3 to 0.

## Operation
- **Reset values:** `select`=0, `asciiDigits`=32'h20202020 (blank), `frameTick`=0, `wrReady`=0 during reset. The block enters EMPTY with length 0 and window start 0.
- **States:**
  - EMPTY: `wrReady`=1.
  - LOADING: `wrReady`=1.
  - RUN: `wrReady`=0.
- **Transfers:** a character is transferred when `wrValid && wrReady`.
  - It is written at the write pointer, and length increments.
  - EMPTY goes to LOADING on the first transfer.
  - LOADING goes to RUN on a transfer with `wrLast`=1, or on the transfer that makes length = MSG_DEPTH. Extra characters are not accepted because `wrReady` drops.
  - In EMPTY, a transfer with `wrLast`=1 goes directly to RUN with length 1.
  - A transfer has no effect in RUN.
- **Clear:** in any state, `clear`=1 goes to EMPTY and resets length and window start to 0. If `clear` and a transfer coincide, clear wins and the character is discarded.
- **Window content, mode 1:**
  - Static (length ≤ 4, or state ≠ RUN): leftmost digit = buf[0]. Positions at or beyond length show 8'h20.
  - Scroll (RUN and length > 4): a virtual sequence of the message followed by 4 spaces, period L = length+4. Leftmost digit = seq[start], next = seq[(start+1) mod L], and so on.
  - On each `SCROLL_DIV`-th frame, start advances by one, and wraps from L−1 to 0.
- **Window content, mode 0:** each nibble of `hexValue` maps to '0'–'9' (8'h30–8'h39) or 'A'–'F' (8'h41–8'h46). Nibble [15:12] goes to the leftmost digit.
- **Tear-free update:** `asciiDigits` is updated only on a frame boundary, in the same cycle as `frameTick`. `mode`, `hexValue` and buffer changes take effect at the next boundary. On a mode change, start and the scroll counter reset to 0.

## Timing
- **Refresh counter:** runs 0..REFRESH_DIV−1. At the terminal count, `select` increments modulo 4.
- **Frame:** one frame = 4·REFRESH_DIV cycles.
- **Frame tick:** `frameTick` is asserted in the cycle `select` becomes 0. The first tick comes 4·REFRESH_DIV cycles after reset release.
- **Scroll counter:** counts frames 0..SCROLL_DIV−1. Start advances on the frame at the terminal count, so the step period is SCROLL_DIV frames.
- **Output latency:** buffer or mode changes appear on `asciiDigits` at the first frame boundary after the change is registered. Worst case is 4·REFRESH_DIV cycles.
- **Handshake:** `wrReady` is registered. After the final transfer it deasserts in the next cycle.
- **Widths:**
  - length: $clog2(MSG_DEPTH+1) bits.
  - start: $clog2(MSG_DEPTH+4) bits.
  - Modulo indexing uses a compare-and-subtract, not a divider.
- **Mid-operation reset:** `rst_n` low during LOADING or RUN returns all outputs to their reset values at the next clk edge.

## Structure
- Shared package `seg7_pkg`:
  - state enum {EMPTY, LOADING, RUN}
  - `ASCII_SPACE` = 8'h20
  - function `hex_nibble_to_ascii`
- Sub-module `seg7_refresh_timer`: contains the refresh counter and the `select`/`frameTick` generation, parameterised by `REFRESH_DIV`.
- Top level: the buffer, the FSM, the scroll logic and the window register.

## Test plan
Benches use REFRESH_DIV=2 and SCROLL_DIV=1 unless stated otherwise.
1. **Reset and scan:** release `rst_n`. Expect `select` sequence 0,0,1,1,2,2,3,3,0; `frameTick` pulses at cycle 8; `asciiDigits`=32'h20202020.
2. **Hex mode:** mode=0, hexValue=16'hA3F0. After the next frameTick, expect `asciiDigits`=32'h41334630 ("A3F0"). Change hexValue mid-frame; expect `asciiDigits` unchanged until the next tick.
3. **Short message:** mode=1, stream "HI" with `wrLast` on 'I'. Expect `wrReady`=0 from the next cycle; next frame `asciiDigits`=32'h48492020; the value stays static over 10 frames.
4. **Scrolling:** stream "HELLO" (L=9). Expect the window sequence "HELL", "ELLO", "LLO ", …, "   H", then a wrap back to "HELL" after 9 frames.
5. **Overflow:** MSG_DEPTH=16, stream 20 characters with no `wrLast`. Expect exactly 16 transfers, `wrReady` low after the 16th, and state RUN.
6. **Clear collision:** assert `clear` together with a valid transfer during LOADING. Expect state EMPTY, length 0, the character discarded, and `wrReady`=1 in the next cycle.
